// File: rtl/jtframe_romarb_pkg.sv
// Shared types for the jtframe ROM arbiter: FSM states, grant index width, timeout counter width.
package jtframe_romarb_pkg;

    typedef enum logic [1:0] {StIdle, StReq, StWait} state_e;

    localparam int unsigned GntW = 3;
    localparam int unsigned CntW = 8;

endpackage

// File: rtl/jtframe_romarb_slot.sv
// One-entry read cache for a single ROM requester: tag/valid/data registers and hit compare.
module jtframe_romarb_slot #(
    parameter int unsigned AW = 22,
    parameter int unsigned DW = 32
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          cs,
    input  logic [AW-1:0] addr,
    input  logic          fill,
    input  logic [AW-1:0] fill_tag,
    input  logic [DW-1:0] fill_data,
    output logic          hit,
    output logic [DW-1:0] dout
);

    logic          valid_q, valid_d;
    logic [AW-1:0] tag_q, tag_d;
    logic [DW-1:0] dout_q, dout_d;

    always_comb begin
        valid_d = valid_q;
        tag_d   = tag_q;
        dout_d  = dout_q;
        if (fill) begin
            valid_d = 1'b1;
            tag_d   = fill_tag;
            dout_d  = fill_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            tag_q   <= '0;
            dout_q  <= '0;
        end else begin
            valid_q <= valid_d;
            tag_q   <= tag_d;
            dout_q  <= dout_d;
        end
    end

    assign hit  = cs & valid_q & (addr == tag_q);
    assign dout = dout_q;

endmodule

// File: rtl/jtframe_rom_arb.sv
// Shares one SDRAM read port among SLOTS cached ROM requesters, one transaction in flight.
// Define JTFRAME_ROMARB_RR_EN for round-robin grant; fixed priority (lowest index) otherwise.
module jtframe_rom_arb
    import jtframe_romarb_pkg::*;
#(
    parameter int unsigned SLOTS   = 5,
    parameter int unsigned AW      = 22,
    parameter int unsigned DW      = 32,
    parameter int unsigned TIMEOUT = 255
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                downloading,
    input  logic                loop_rst,
    input  logic [SLOTS-1:0]    slot_cs,
    input  logic [SLOTS*AW-1:0] slot_addr,
    output logic [SLOTS-1:0]    slot_ok,
    output logic [SLOTS*DW-1:0] slot_dout,
    output logic                sdram_req,
    output logic [AW-1:0]       sdram_addr,
    input  logic                sdram_ack,
    input  logic                data_rdy,
    input  logic [DW-1:0]       data_read,
    output logic                refresh_en,
    output logic [GntW-1:0]     gnt_slot
);

    state_e                 state_q, state_d;
    logic                   req_q, req_d;
    logic [AW-1:0]          addr_q, addr_d;
    logic [GntW-1:0]        gnt_q, gnt_d;
    logic [CntW-1:0]        cnt_q, cnt_d;

    logic                   hold;
    logic [SLOTS-1:0]       hit, miss, fill;
    logic                   any_miss, do_fill;
    logic [GntW-1:0]        win;
    logic [AW-1:0]          win_addr;

    assign hold = rst | loop_rst | downloading;

    for (genvar g = 0; g < SLOTS; g++) begin : g_slot
        jtframe_romarb_slot #(
            .AW (AW),
            .DW (DW)
        ) u_slot (
            .clk       (clk),
            .rst       (hold),
            .cs        (slot_cs[g]),
            .addr      (slot_addr[g*AW +: AW]),
            .fill      (fill[g]),
            .fill_tag  (addr_q),
            .fill_data (data_read),
            .hit       (hit[g]),
            .dout      (slot_dout[g*DW +: DW])
        );
    end

    // Cache state is only cleared on the next edge, so mask hits/misses while held.
    assign slot_ok    = hold ? '0 : hit;
    assign miss       = hold ? '0 : (slot_cs & ~hit);
    assign any_miss   = |miss;
    assign refresh_en = hold | ((state_q == StIdle) & ~any_miss);
    assign sdram_req  = req_q;
    assign sdram_addr = addr_q;
    assign gnt_slot   = gnt_q;
    assign fill       = do_fill ? (SLOTS'(1) << gnt_q) : '0;

    always_comb begin
        int unsigned idx;
        logic        found;
        idx   = 0;
        found = 1'b0;
        win   = '0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
`ifdef JTFRAME_ROMARB_RR_EN
            idx = (32'(gnt_q) + 32'd1 + k) % SLOTS;
`else
            idx = k;
`endif
            if (!found && miss[idx]) begin
                found = 1'b1;
                win   = GntW'(idx);
            end
        end
    end

    always_comb begin
        win_addr = '0;
        for (int unsigned k = 0; k < SLOTS; k++) begin
            if (GntW'(k) == win) win_addr = slot_addr[k*AW +: AW];
        end
    end

    always_ff @(posedge clk) begin
        if (hold) begin
            state_q <= StIdle;
            req_q   <= 1'b0;
            addr_q  <= '0;
            gnt_q   <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            addr_q  <= addr_d;
            gnt_q   <= gnt_d;
            cnt_q   <= cnt_d;
        end
    end

    // Counter is 0 on the first WAIT cycle, so TIMEOUT WAIT cycles end at TIMEOUT-1.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: if (any_miss) state_d = StReq;
            StReq: begin
                if (sdram_ack) state_d = data_rdy ? StIdle : StWait;
            end
            StWait: begin
                if (data_rdy || cnt_q == CntW'(TIMEOUT - 1)) state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        req_d   = req_q;
        addr_d  = addr_q;
        gnt_d   = gnt_q;
        cnt_d   = cnt_q;
        do_fill = 1'b0;
        unique case (state_q)
            StIdle: begin
                if (any_miss) begin
                    req_d  = 1'b1;
                    addr_d = win_addr;
                    gnt_d  = win;
                end
            end
            StReq: begin
                if (sdram_ack) begin
                    req_d   = 1'b0;
                    cnt_d   = '0;
                    do_fill = data_rdy;
                end
            end
            StWait: begin
                cnt_d   = cnt_q + CntW'(1);
                do_fill = data_rdy;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_jtframe_rom_arb.sv
// Directed self-checking bench for jtframe_rom_arb (default parameters).
module tb_jtframe_rom_arb;

    localparam int SLOTS = 5;
    localparam int AW    = 22;
    localparam int DW    = 32;

    logic                clk = 1'b0;
    logic                rst, downloading, loop_rst;
    logic [SLOTS-1:0]    slot_cs;
    logic [SLOTS*AW-1:0] slot_addr;
    logic [SLOTS-1:0]    slot_ok;
    logic [SLOTS*DW-1:0] slot_dout;
    logic                sdram_req, sdram_ack, data_rdy, refresh_en;
    logic [AW-1:0]       sdram_addr;
    logic [DW-1:0]       data_read;
    logic [2:0]          gnt_slot;

    int n_checks = 0;
    int n_fail   = 0;

    jtframe_rom_arb dut (
        .clk         (clk),
        .rst         (rst),
        .downloading (downloading),
        .loop_rst    (loop_rst),
        .slot_cs     (slot_cs),
        .slot_addr   (slot_addr),
        .slot_ok     (slot_ok),
        .slot_dout   (slot_dout),
        .sdram_req   (sdram_req),
        .sdram_addr  (sdram_addr),
        .sdram_ack   (sdram_ack),
        .data_rdy    (data_rdy),
        .data_read   (data_read),
        .refresh_en  (refresh_en),
        .gnt_slot    (gnt_slot)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0]  cs;
        logic [21:0] a0, a3, a4;
        logic [4:0]  ok;
        logic        rf;
    } vec_t;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_addr(input int s, input logic [AW-1:0] a);
        slot_addr[s*AW +: AW] = a;
    endtask

    function automatic logic [DW-1:0] dout_of(input int s);
        return slot_dout[s*DW +: DW];
    endfunction

    task automatic do_reset();
        rst = 1'b1; downloading = 1'b0; loop_rst = 1'b0;
        slot_cs = '0; slot_addr = '0;
        sdram_ack = 1'b0; data_rdy = 1'b0; data_read = '0;
        tick(); tick();
        rst = 1'b0;
    endtask

    task automatic wait_req(input int s, input logic [AW-1:0] a);
        int n = 0;
        while (!sdram_req && n < 40) begin tick(); n++; end
        check($sformatf("req_seen_s%0d", s), 64'(sdram_req), 64'(1));
        check($sformatf("req_addr_s%0d", s), 64'(sdram_addr), 64'(a));
        check($sformatf("gnt_slot_s%0d", s), 64'(gnt_slot), 64'(s));
    endtask

    task automatic do_ack(input int delay);
        repeat (delay) tick();
        sdram_ack = 1'b1;
        tick();
        sdram_ack = 1'b0;
        check("req_drop_after_ack", 64'(sdram_req), 64'(0));
    endtask

    task automatic do_rdy(input int delay, input logic [DW-1:0] d);
        repeat (delay) tick();
        data_rdy = 1'b1; data_read = d;
        tick();
        data_rdy = 1'b0; data_read = '0;
    endtask

    task automatic serve(input int s, input logic [AW-1:0] a, input logic [DW-1:0] d);
        wait_req(s, a);
        do_ack(1);
        do_rdy(3, d);
        check($sformatf("ok_after_fill_s%0d", s), 64'(slot_ok[s]), 64'(1));
        check($sformatf("dout_s%0d", s), 64'(dout_of(s)), 64'(d));
    endtask

    initial begin
        vec_t tbl[6];
        int   order2[3];
        int   order6[5];
        int   n;
        logic [AW-1:0] a2[5];

`ifdef JTFRAME_ROMARB_RR_EN
        order2 = '{4, 0, 3};
        order6 = '{1, 2, 3, 4, 0};
`else
        order2 = '{0, 3, 4};
        order6 = '{0, 1, 2, 3, 4};
`endif
        tbl[0] = '{cs: 5'b11001, a0: 22'h100, a3: 22'h333, a4: 22'h400, ok: 5'b11001, rf: 1'b1};
        tbl[1] = '{cs: 5'b00001, a0: 22'h100, a3: 22'h333, a4: 22'h400, ok: 5'b00001, rf: 1'b1};
        tbl[2] = '{cs: 5'b11001, a0: 22'h100, a3: 22'h333, a4: 22'h401, ok: 5'b01001, rf: 1'b0};
        tbl[3] = '{cs: 5'b00000, a0: 22'h100, a3: 22'h333, a4: 22'h400, ok: 5'b00000, rf: 1'b1};
        tbl[4] = '{cs: 5'b00010, a0: 22'h100, a3: 22'h333, a4: 22'h400, ok: 5'b00000, rf: 1'b0};
        tbl[5] = '{cs: 5'b11000, a0: 22'h100, a3: 22'h100, a4: 22'h400, ok: 5'b10000, rf: 1'b0};

        // 1: single miss, fill, then repeat hits
        do_reset();
        check("rst_req", 64'(sdram_req), 64'(0));
        check("rst_addr", 64'(sdram_addr), 64'(0));
        check("rst_ok", 64'(slot_ok), 64'(0));
        check("rst_dout", 64'(slot_dout[63:0]), 64'(0));
        check("rst_refresh", 64'(refresh_en), 64'(1));
        check("rst_gnt", 64'(gnt_slot), 64'(0));
        slot_cs[2] = 1'b1; set_addr(2, 22'h1234);
        #1;
        check("miss_refresh_low", 64'(refresh_en), 64'(0));
        tick();
        check("req_latency_1", 64'(sdram_req), 64'(1));
        wait_req(2, 22'h1234);
        do_ack(1);
        repeat (4) tick();
        check("ok_before_rdy", 64'(slot_ok[2]), 64'(0));
        do_rdy(0, 32'hDEADBEEF);
        check("t1_ok", 64'(slot_ok[2]), 64'(1));
        check("t1_dout", 64'(dout_of(2)), 64'(32'hDEADBEEF));
        n = 0;
        repeat (10) begin tick(); if (sdram_req) n++; end
        check("t1_no_rerequest", 64'(n), 64'(0));
        check("t1_refresh_idle", 64'(refresh_en), 64'(1));

        // 2: three simultaneous misses, after a grant to slot 3
        do_reset();
        slot_cs[3] = 1'b1; set_addr(3, 22'h300);
        serve(3, 22'h300, 32'hA3A3A3A3);
        a2[0] = 22'h100; a2[3] = 22'h333; a2[4] = 22'h400;
        set_addr(0, a2[0]); set_addr(3, a2[3]); set_addr(4, a2[4]);
        slot_cs = 5'b11001;
        for (int i = 0; i < 3; i++) serve(order2[i], a2[order2[i]], 32'hC0DE0000 + 32'(order2[i]));
        check("t2_all_ok", 64'(slot_ok), 64'(5'b11001));

        // Hit table against the caches left by test 2; all within one clock period
        for (int i = 0; i < 6; i++) begin
            slot_cs = tbl[i].cs;
            set_addr(0, tbl[i].a0); set_addr(1, 22'h3);
            set_addr(3, tbl[i].a3); set_addr(4, tbl[i].a4);
            #1;
            check($sformatf("tbl%0d_ok", i), 64'(slot_ok), 64'(tbl[i].ok));
            check($sformatf("tbl%0d_refresh", i), 64'(refresh_en), 64'(tbl[i].rf));
        end
        slot_cs = '0;

        // 3: address changes while in flight
        do_reset();
        slot_cs[1] = 1'b1; set_addr(1, 22'h10);
        wait_req(1, 22'h10);
        do_ack(1);
        set_addr(1, 22'h20);
        do_rdy(2, 32'h11110010);
        check("t3_ok_low", 64'(slot_ok[1]), 64'(0));
        set_addr(1, 22'h10);
        #1;
        check("t3_tag_grant", 64'(slot_ok[1]), 64'(1));
        check("t3_dout_grant", 64'(dout_of(1)), 64'(32'h11110010));
        set_addr(1, 22'h20);
        serve(1, 22'h20, 32'h11110020);

        // 4: loop_rst during WAIT discards the late data
        do_reset();
        slot_cs[0] = 1'b1; set_addr(0, 22'h555);
        wait_req(0, 22'h555);
        do_ack(0);
        loop_rst = 1'b1; slot_cs = '0;
        tick();
        check("t4_req_in_rst", 64'(sdram_req), 64'(0));
        check("t4_refresh_in_rst", 64'(refresh_en), 64'(1));
        loop_rst = 1'b0;
        do_rdy(0, 32'hBAD0BAD0);
        check("t4_req", 64'(sdram_req), 64'(0));
        check("t4_refresh", 64'(refresh_en), 64'(1));
        slot_cs[0] = 1'b1;
        #1;
        check("t4_no_fill", 64'(slot_ok[0]), 64'(0));
        serve(0, 22'h555, 32'h0000F00D);

        // 5: no data_rdy -> timeout and retry of the same slot
        do_reset();
        slot_cs[4] = 1'b1; set_addr(4, 22'h3ABCD);
        wait_req(4, 22'h3ABCD);
        do_ack(0);
        n = 0;
        while (!sdram_req && n < 400) begin tick(); n++; end
        check("t5_timeout_cycles", 64'(n), 64'(256));
        check("t5_ok_low", 64'(slot_ok[4]), 64'(0));
        wait_req(4, 22'h3ABCD);
        do_ack(0);
        do_rdy(1, 32'h44444444);
        check("t5_ok", 64'(slot_ok[4]), 64'(1));

        // 6: downloading holds the arbiter idle
        do_reset();
        downloading = 1'b1;
        slot_cs = '1;
        for (int s = 0; s < SLOTS; s++) begin a2[s] = 22'h2000 + 22'(s); set_addr(s, a2[s]); end
        n = 0;
        repeat (10) begin tick(); if (sdram_req || !refresh_en || slot_ok != 0) n++; end
        check("t6_held_idle", 64'(n), 64'(0));
        downloading = 1'b0;
        for (int i = 0; i < SLOTS; i++) serve(order6[i], a2[order6[i]], 32'h66000000 + 32'(order6[i]));
        check("t6_all_ok", 64'(slot_ok), 64'(5'b11111));
        check("t6_refresh", 64'(refresh_en), 64'(1));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
